spio_hss_multiplexer_retx_store: RTL and testbench
==================================================

Name: spio_hss_multiplexer_retx_store

Overview:
- Parametrised go-back-N retransmit packet store for the HSS multiplexer frame assembler.
- Accepts packets from the packet interface and hands them, one per request, to frame issue. Keeps every sent packet until it is acked, and rewinds on nak.
- Adds the following to the existing fixed-size store: full-depth use via wrap-bit pointers, flush, occupancy/unread counts, a per-packet retransmit flag and a saturating nak counter.

Parameters:
PKT_BITS, 72, packet width in bits
BUF_BITS, 3, log2 of buffer depth; DEPTH = 2**BUF_BITS
SEQ_BITS, 7, frame sequence number width; must be >= BUF_BITS
PLD_BIT, 1, index in pkt_data of the payload-present bit
CNT_BITS, 16, width of the nak counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous pointer clear
cfc_rem  in  1  remote channel flow control; 1 = sending allowed
vld_ack  in  1  ack strobe
vld_nak  in  1  nak strobe
ack_seq  in  SEQ_BITS  sequence number carried by ack/nak
pkt_data  in  PKT_BITS  incoming packet
pkt_vld  in  1  incoming packet valid
pkt_rdy  out  1  store can accept a packet
bpkt_seq  in  SEQ_BITS  sequence number of the frame slot being requested
bpkt_rq  in  1  frame issue requests a packet
bpkt_gt  out  1  request granted; data valid this cycle
bpkt_pres  out  1  last request returned a packet
bpkt_data  out  PKT_BITS  granted packet
bpkt_pld  out  1  granted packet has payload
bpkt_retx  out  1  granted packet is a resend
empty  out  1  no unread packets
full  out  1  DEPTH packets held (unacked + unread)
occupancy  out  BUF_BITS+1  packets held, bw-ba
unread_cnt  out  BUF_BITS+1  packets not yet sent, bw-br
nak_cnt  out  CNT_BITS  naks received, saturating

Behaviour:
- Pointers are BUF_BITS+1 bits wide; the MSB is the wrap bit. Pointers are ba (oldest unacked), br (next to send), bs (send high-water) and bw (write). Invariant: ba <= br <= bs <= bw, modulo wrap.
- full = (bw-ba == DEPTH). empty = (bw == br). Both are registered from next-state values.
- writing = pkt_vld && !full. On writing: buf[bw] <= pkt_data, then bw+1.
- reading = bpkt_rq && !empty && cfc_rem && !vld_nak. On reading: br+1, and the slot at br is latched for output.
- bs advances with br when reading and br == bs.
- seq_map[bpkt_seq[BUF_BITS-1:0]] <= br on every bpkt_rq, whether or not the read succeeds.
- Ack rules: frame ack_seq is not acked; all earlier frames are acked.
  - If ack_seq == bpkt_seq: ba <= br.
  - Otherwise: ba <= seq_map[ack_seq].
- Nak: ba <= br <= seq_map[ack_seq]. Nak takes priority over ack and over a read in the same cycle.
- nak_cnt increments on each vld_nak and holds at all-ones.
- Write, read and ack in the same cycle all take effect; counts use the next-state pointers.
- Output latency is one cycle. The cycle after reading: bpkt_gt=1, bpkt_data=buf[br_old], bpkt_pld=bit PLD_BIT of that packet, bpkt_retx=(br_old != bs_old).
- bpkt_pres is updated only on bpkt_rq cycles, to the value of reading; it holds otherwise.
- bpkt_gt=0 in all cycles where no read occurred.
- pkt_rdy is registered: pkt_rdy <= !nxt_full.
- flush: all pointers go to 0; bpkt_gt, bpkt_pres and bpkt_retx go to 0. Any write or read in that cycle is ignored. nak_cnt is kept. pkt_rdy=1 the next cycle.
- Reset values: all pointers 0; empty=1; full=0; pkt_rdy=0 (rises to 1 the first cycle after rst drops); bpkt_gt=0; bpkt_pres=0; bpkt_retx=0; bpkt_data=0; occupancy=0; unread_cnt=0; nak_cnt=0.
- Reset mid-operation discards buffered packets.
- Buffer RAM is not reset.
- rst has priority over flush.
- Pointer wrap: all pointer arithmetic is modulo 2**(BUF_BITS+1).

Test Plan:
- Reset then write 8 packets (DEPTH=8) with no reads → full=1, pkt_rdy=0 after the 8th, occupancy=8; a 9th pkt_vld is not accepted.
- Write 3 packets; issue 3 bpkt_rq with seq 0,1,2 and cfc_rem=1 → bpkt_gt pulses one cycle after each rq, data in order, bpkt_retx=0, unread_cnt=0, occupancy=3.
- Send seq 0..4, then nak with ack_seq=2 → ba=br=2, nak_cnt=1; the next 3 grants return packets 2,3,4 with bpkt_retx=1, then new packets with bpkt_retx=0.
- Ack with ack_seq=3 after sending 0..4 → occupancy drops from 5 to 2. Then ack with ack_seq==bpkt_seq → occupancy=0.
- bpkt_rq with cfc_rem=0, or while empty → bpkt_gt=0, bpkt_pres=0, br unchanged. Nak and rq in the same cycle → no grant, rewind applied.
- Fill to 5 and assert flush together with pkt_vld → occupancy=0, empty=1, the write is dropped, nak_cnt is unchanged. Wrap test: 20 write/send/ack cycles at DEPTH=8 show no data corruption.

Source files
------------

// File: rtl/spio_hss_multiplexer_retx_store.sv
`default_nettype none
// ============================================================================
// Module   : spio_hss_multiplexer_retx_store
// Purpose  : Go-back-N retransmit packet store for the HSS multiplexer frame
//            assembler. Holds every sent packet until acked, rewinds on nak,
//            and supports flush, occupancy/unread counts, a per-packet resend
//            flag and a saturating nak counter.
// Revision : 1.0 - initial release
// ============================================================================
module spio_hss_multiplexer_retx_store #(
    parameter int PKT_BITS = 72,
    parameter int BUF_BITS = 3,
    parameter int SEQ_BITS = 7,
    parameter int PLD_BIT  = 1,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                cfc_rem,
    input  logic                vld_ack,
    input  logic                vld_nak,
    input  logic [SEQ_BITS-1:0] ack_seq,
    input  logic [PKT_BITS-1:0] pkt_data,
    input  logic                pkt_vld,
    output logic                pkt_rdy,
    input  logic [SEQ_BITS-1:0] bpkt_seq,
    input  logic                bpkt_rq,
    output logic                bpkt_gt,
    output logic                bpkt_pres,
    output logic [PKT_BITS-1:0] bpkt_data,
    output logic                bpkt_pld,
    output logic                bpkt_retx,
    output logic                empty,
    output logic                full,
    output logic [BUF_BITS:0]   occupancy,
    output logic [BUF_BITS:0]   unread_cnt,
    output logic [CNT_BITS-1:0] nak_cnt
);

    localparam int DEPTH = 1 << BUF_BITS;
    localparam int PW    = BUF_BITS + 1;
    localparam logic [PW-1:0] c_depth = PW'(DEPTH);
    localparam logic [PW-1:0] c_one   = PW'(1);

    // Packet buffer and frame-sequence to read-pointer map (not reset)
    logic [PKT_BITS-1:0] r_buf     [DEPTH];
    logic [PW-1:0]       r_seq_map [DEPTH];

    // Pointers carry a wrap bit in the MSB so all DEPTH slots are usable
    logic [PW-1:0] r_ba, r_br, r_bs, r_bw;
    logic [PW-1:0] w_nxt_ba, w_nxt_br, w_nxt_bs, w_nxt_bw;
    logic [PW-1:0] w_map_ack;
    logic          w_writing, w_reading;

    logic                r_empty, r_full, r_pkt_rdy;
    logic                r_gt, r_pres, r_retx;
    logic [PKT_BITS-1:0] r_data;
    logic [CNT_BITS-1:0] r_nak_cnt;

    assign w_map_ack = r_seq_map[ack_seq[BUF_BITS-1:0]];
    assign w_writing = pkt_vld && !r_full && !flush;
    assign w_reading = bpkt_rq && !r_empty && cfc_rem && !vld_nak && !flush;

    // Next-state pointers: flush clears, nak rewinds and overrides ack/read
    always_comb begin
        w_nxt_ba = r_ba;
        w_nxt_br = r_br;
        w_nxt_bs = r_bs;
        w_nxt_bw = r_bw;
        if (flush) begin
            w_nxt_ba = '0;
            w_nxt_br = '0;
            w_nxt_bs = '0;
            w_nxt_bw = '0;
        end else begin
            if (w_writing)
                w_nxt_bw = r_bw + c_one;
            if (vld_nak) begin
                w_nxt_ba = w_map_ack;
                w_nxt_br = w_map_ack;
            end else begin
                if (w_reading) begin
                    w_nxt_br = r_br + c_one;
                    if (r_br == r_bs)
                        w_nxt_bs = r_bs + c_one;
                end
                // Frame ack_seq itself is not acked; everything before it is
                if (vld_ack)
                    w_nxt_ba = (ack_seq == bpkt_seq) ? r_br : w_map_ack;
            end
        end
    end

    // Pointer registers and status flags derived from next-state pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ba      <= '0;
            r_br      <= '0;
            r_bs      <= '0;
            r_bw      <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_pkt_rdy <= 1'b0;
        end else begin
            r_ba      <= w_nxt_ba;
            r_br      <= w_nxt_br;
            r_bs      <= w_nxt_bs;
            r_bw      <= w_nxt_bw;
            r_empty   <= (w_nxt_bw == w_nxt_br);
            r_full    <= ((w_nxt_bw - w_nxt_ba) == c_depth);
            r_pkt_rdy <= ((w_nxt_bw - w_nxt_ba) != c_depth);
        end
    end

    // Buffer write and sequence map capture on every request
    always_ff @(posedge clk) begin
        if (w_writing)
            r_buf[r_bw[BUF_BITS-1:0]] <= pkt_data;
        if (bpkt_rq)
            r_seq_map[bpkt_seq[BUF_BITS-1:0]] <= r_br;
    end

    // Grant outputs, one cycle after a successful read
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gt   <= 1'b0;
            r_pres <= 1'b0;
            r_retx <= 1'b0;
            r_data <= '0;
        end else if (flush) begin
            r_gt   <= 1'b0;
            r_pres <= 1'b0;
            r_retx <= 1'b0;
        end else begin
            r_gt <= w_reading;
            if (w_reading) begin
                r_data <= r_buf[r_br[BUF_BITS-1:0]];
                r_retx <= (r_br != r_bs);
            end
            if (bpkt_rq)
                r_pres <= w_reading;
        end
    end

    // Saturating nak counter, survives flush
    always_ff @(posedge clk) begin
        if (rst)
            r_nak_cnt <= '0;
        else if (vld_nak && !(&r_nak_cnt))
            r_nak_cnt <= r_nak_cnt + CNT_BITS'(1);
    end

    assign pkt_rdy    = r_pkt_rdy;
    assign bpkt_gt    = r_gt;
    assign bpkt_pres  = r_pres;
    assign bpkt_data  = r_data;
    assign bpkt_pld   = r_data[PLD_BIT];
    assign bpkt_retx  = r_retx;
    assign empty      = r_empty;
    assign full       = r_full;
    assign occupancy  = r_bw - r_ba;
    assign unread_cnt = r_bw - r_br;
    assign nak_cnt    = r_nak_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spio_hss_multiplexer_retx_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_spio_hss_multiplexer_retx_store
// Purpose  : Directed self-checking bench for the retransmit packet store.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spio_hss_multiplexer_retx_store;

    localparam int PKT_BITS = 72;
    localparam int BUF_BITS = 3;
    localparam int SEQ_BITS = 7;
    localparam int CNT_BITS = 16;

    logic                clk = 1'b0;
    logic                rst, flush, cfc_rem, vld_ack, vld_nak;
    logic [SEQ_BITS-1:0] ack_seq, bpkt_seq;
    logic [PKT_BITS-1:0] pkt_data;
    logic                pkt_vld, pkt_rdy, bpkt_rq, bpkt_gt, bpkt_pres;
    logic [PKT_BITS-1:0] bpkt_data;
    logic                bpkt_pld, bpkt_retx, empty, full;
    logic [BUF_BITS:0]   occupancy, unread_cnt;
    logic [CNT_BITS-1:0] nak_cnt;

    int total = 0;
    int bad   = 0;

    spio_hss_multiplexer_retx_store #(
        .PKT_BITS(PKT_BITS), .BUF_BITS(BUF_BITS), .SEQ_BITS(SEQ_BITS),
        .PLD_BIT(1), .CNT_BITS(CNT_BITS)
    ) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .cfc_rem(cfc_rem),
        .vld_ack(vld_ack), .vld_nak(vld_nak), .ack_seq(ack_seq),
        .pkt_data(pkt_data), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy),
        .bpkt_seq(bpkt_seq), .bpkt_rq(bpkt_rq), .bpkt_gt(bpkt_gt),
        .bpkt_pres(bpkt_pres), .bpkt_data(bpkt_data), .bpkt_pld(bpkt_pld),
        .bpkt_retx(bpkt_retx), .empty(empty), .full(full),
        .occupancy(occupancy), .unread_cnt(unread_cnt), .nak_cnt(nak_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PKT_BITS-1:0] pkt(input int n);
        return {8'hA5, 32'(n), 24'h5A5A5A, 8'(n)};
    endfunction

    task automatic check(input string tag, input logic [PKT_BITS-1:0] obs,
                         input logic [PKT_BITS-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; vld_ack = 0; vld_nak = 0; pkt_vld = 0; bpkt_rq = 0;
    endtask

    task automatic wr(input int n);
        pkt_vld = 1; pkt_data = pkt(n);
        tick();
        pkt_vld = 0;
    endtask

    task automatic rq(input int seq);
        bpkt_rq = 1; bpkt_seq = SEQ_BITS'(seq);
        tick();
        bpkt_rq = 0;
    endtask

    // Request and check the grant that appears on the following cycle
    task automatic rq_chk(input string tag, input int seq, input int n, input logic retx);
        rq(seq);
        check({tag, ".gt"}, 72'(bpkt_gt), 72'(1));
        check({tag, ".data"}, bpkt_data, pkt(n));
        check({tag, ".pld"}, 72'(bpkt_pld), 72'(n[1]));
        check({tag, ".retx"}, 72'(bpkt_retx), 72'(retx));
    endtask

    task automatic ack(input int aseq, input int bseq);
        vld_ack = 1; ack_seq = SEQ_BITS'(aseq); bpkt_seq = SEQ_BITS'(bseq);
        tick();
        vld_ack = 0;
    endtask

    initial begin
        rst = 1; cfc_rem = 1; ack_seq = '0; bpkt_seq = '0; pkt_data = '0;
        idle();
        tick(); tick();
        check("rst.empty", 72'(empty), 72'(1));
        check("rst.full", 72'(full), 72'(0));
        check("rst.rdy", 72'(pkt_rdy), 72'(0));
        check("rst.gt", 72'(bpkt_gt), 72'(0));
        check("rst.pres", 72'(bpkt_pres), 72'(0));
        check("rst.retx", 72'(bpkt_retx), 72'(0));
        check("rst.data", bpkt_data, 72'(0));
        check("rst.occ", 72'(occupancy), 72'(0));
        check("rst.unread", 72'(unread_cnt), 72'(0));
        check("rst.nak", 72'(nak_cnt), 72'(0));
        rst = 0;
        tick();
        check("rst.rdy_rise", 72'(pkt_rdy), 72'(1));

        // Fill to full depth; a ninth write must be dropped
        for (int i = 0; i < 8; i++) wr(i);
        check("fill.full", 72'(full), 72'(1));
        check("fill.rdy", 72'(pkt_rdy), 72'(0));
        check("fill.occ", 72'(occupancy), 72'(8));
        wr(99);
        check("fill9.occ", 72'(occupancy), 72'(8));
        rq_chk("fill.rd0", 0, 0, 0);
        check("fill.unread", 72'(unread_cnt), 72'(7));
        check("fill.occ_rd", 72'(occupancy), 72'(8));
        flush = 1; tick(); flush = 0;
        check("fl0.occ", 72'(occupancy), 72'(0));
        check("fl0.rdy", 72'(pkt_rdy), 72'(1));
        check("fl0.gt", 72'(bpkt_gt), 72'(0));

        // Three writes, three in-order grants
        for (int i = 0; i < 3; i++) wr(10 + i);
        for (int i = 0; i < 3; i++) begin
            rq_chk("rd3", i, 10 + i, 0);
            check("rd3.pres", 72'(bpkt_pres), 72'(1));
        end
        tick();
        check("rd3.gt_drop", 72'(bpkt_gt), 72'(0));
        check("rd3.pres_hold", 72'(bpkt_pres), 72'(1));
        check("rd3.unread", 72'(unread_cnt), 72'(0));
        check("rd3.occ", 72'(occupancy), 72'(3));
        ack(3, 3);
        check("rd3.ack_occ", 72'(occupancy), 72'(0));

        // Send five, nak at seq 2, observe resends then fresh packets
        for (int i = 0; i < 5; i++) wr(20 + i);
        for (int i = 0; i < 5; i++) rq_chk("nk.first", i, 20 + i, 0);
        vld_nak = 1; ack_seq = 7'd2; tick(); vld_nak = 0;
        check("nk.cnt", 72'(nak_cnt), 72'(1));
        check("nk.occ", 72'(occupancy), 72'(3));
        check("nk.unread", 72'(unread_cnt), 72'(3));
        wr(25); wr(26);
        for (int i = 0; i < 3; i++) rq_chk("nk.resend", 5 + i, 22 + i, 1);
        rq_chk("nk.new0", 8, 25, 0);
        rq_chk("nk.new1", 9, 26, 0);
        ack(10, 10);
        check("nk.ack_occ", 72'(occupancy), 72'(0));

        // Partial ack then full ack
        for (int i = 0; i < 5; i++) wr(30 + i);
        for (int i = 0; i < 5; i++) rq_chk("ak", i, 30 + i, 0);
        check("ak.occ5", 72'(occupancy), 72'(5));
        ack(3, 5);
        check("ak.occ2", 72'(occupancy), 72'(2));
        ack(5, 5);
        check("ak.occ0", 72'(occupancy), 72'(0));

        // Flow control, nak colliding with a request, and empty requests
        wr(40);
        cfc_rem = 0; rq(5); cfc_rem = 1;
        check("cfc.gt", 72'(bpkt_gt), 72'(0));
        check("cfc.pres", 72'(bpkt_pres), 72'(0));
        check("cfc.unread", 72'(unread_cnt), 72'(1));
        rq_chk("cfc.rd", 6, 40, 0);
        vld_nak = 1; ack_seq = 7'd6; rq(7); vld_nak = 0;
        check("nkrq.gt", 72'(bpkt_gt), 72'(0));
        check("nkrq.pres", 72'(bpkt_pres), 72'(0));
        check("nkrq.unread", 72'(unread_cnt), 72'(1));
        check("nkrq.cnt", 72'(nak_cnt), 72'(2));
        rq_chk("nkrq.resend", 7, 40, 1);
        rq(8);
        check("emp.gt", 72'(bpkt_gt), 72'(0));
        check("emp.pres", 72'(bpkt_pres), 72'(0));
        check("emp.empty", 72'(empty), 72'(1));
        ack(9, 9);
        check("emp.occ", 72'(occupancy), 72'(0));

        // Flush with a concurrent write drops the write and keeps nak_cnt
        for (int i = 0; i < 5; i++) wr(50 + i);
        check("fl.occ5", 72'(occupancy), 72'(5));
        flush = 1; pkt_vld = 1; pkt_data = pkt(99); tick(); flush = 0; pkt_vld = 0;
        check("fl.occ", 72'(occupancy), 72'(0));
        check("fl.empty", 72'(empty), 72'(1));
        check("fl.unread", 72'(unread_cnt), 72'(0));
        check("fl.nak", 72'(nak_cnt), 72'(2));
        check("fl.rdy", 72'(pkt_rdy), 72'(1));
        wr(60);
        rq_chk("fl.after", 0, 60, 0);
        ack(1, 1);

        // Wrap: repeated write/send/ack across several pointer wraps
        for (int i = 0; i < 20; i++) begin
            wr(100 + i);
            rq_chk("wrap", i, 100 + i, 0);
            ack(i + 1, i + 1);
        end
        check("wrap.occ", 72'(occupancy), 72'(0));
        check("wrap.empty", 72'(empty), 72'(1));

        // Reset mid-operation discards buffered packets
        wr(70); wr(71);
        rst = 1; tick(); rst = 0;
        check("rst2.occ", 72'(occupancy), 72'(0));
        check("rst2.empty", 72'(empty), 72'(1));
        check("rst2.nak", 72'(nak_cnt), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
